// File: rtl/bram_sync_ctrl_if.sv
// SD sector handshake between the backup-RAM controller and hps_io.
// The controller is the master: it requests sectors, hps_io acknowledges
// them and streams the sector words through the buffer port.
interface bram_sync_ctrl_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [7:0]  sd_buff_addr;
  logic        sd_buff_wr;

  modport master (
    output sd_lba, sd_rd, sd_wr,
    input  sd_ack, sd_buff_addr, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr,
    output sd_ack, sd_buff_addr, sd_buff_wr
  );
endinterface

// File: rtl/bram_sync_ctrl.sv
// Backup-RAM sync controller: moves the core's BRAM image to and from the
// mounted save file, one 512-byte sector at a time.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for auto-load, manual load/save or autosave trigger
// REQ   | sd_rd/sd_wr raised for sd_lba, waiting for sd_ack to rise
// XFER  | hps_io is moving the sector, waiting for sd_ack to fall
module bram_sync_ctrl #(
  parameter int unsigned SECTORS = 128,
  parameter int unsigned LBA_W   = 7,
  parameter logic [23:0] TIMEOUT = 24'd5000000
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              downloading,
  input  logic              img_mounted,
  input  logic              img_readonly,
  input  logic [63:0]       img_size,
  input  logic              osd_status,
  input  logic              autosave,
  input  logic              load_req,
  input  logic              save_req,
  input  logic              bram_change,
  bram_sync_ctrl_if.master  sd,
  output logic [LBA_W+7:0]  bram_a,
  output logic              bram_we,
  output logic              bk_ena,
  output logic              bk_loading,
  output logic              bk_busy,
  output logic              sav_pending,
  output logic              xfer_done,
  output logic              xfer_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [LBA_W-1:0] lba_q, lba_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic             loading_q, loading_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [23:0]      tmo_q, tmo_d;

  logic load_req_d, save_req_d, sd_ack_d, downloading_d, auto_sv_d;
  logic auto_sv;
  logic start, is_load, save_start, load_done;

  logic load_rise, save_rise, ack_rise, ack_fall, dl_rise, dl_fall, auto_rise;
  logic autoload_trig, last_sector;

  assign auto_sv       = sav_pending & osd_status & autosave;
  assign load_rise     = load_req & ~load_req_d;
  assign save_rise     = save_req & ~save_req_d;
  assign ack_rise      = sd.sd_ack & ~sd_ack_d;
  assign ack_fall      = ~sd.sd_ack & sd_ack_d;
  assign dl_rise       = downloading & ~downloading_d;
  assign dl_fall       = ~downloading & downloading_d;
  assign auto_rise     = auto_sv & ~auto_sv_d;
  assign autoload_trig = dl_fall & (img_size != 64'd0);
  assign last_sector   = (lba_q == LBA_W'(SECTORS - 1));

  // Edge-detect history; tracked even while busy so held levels never fire late.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      load_req_d    <= 1'b0;
      save_req_d    <= 1'b0;
      sd_ack_d      <= 1'b0;
      downloading_d <= 1'b0;
      auto_sv_d     <= 1'b0;
    end else begin
      load_req_d    <= load_req;
      save_req_d    <= save_req;
      sd_ack_d      <= sd.sd_ack;
      downloading_d <= downloading;
      auto_sv_d     <= auto_sv;
    end
  end

  // Save file enable: a new ROM download invalidates it, a writable mount sets it.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bk_ena <= 1'b0;
    end else if (downloading & img_mounted & ~img_readonly) begin
      bk_ena <= 1'b1;
    end else if (dl_rise) begin
      bk_ena <= 1'b0;
    end
  end

  // Dirty flag; a change racing a save start re-arms it so it is not lost.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sav_pending <= 1'b0;
    end else if (bram_change & ~osd_status) begin
      sav_pending <= 1'b1;
    end else if (save_start | load_done) begin
      sav_pending <= 1'b0;
    end
  end

  // FSM state and transfer registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= IDLE;
      lba_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      loading_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      lba_q     <= lba_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      loading_q <= loading_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

  // Next-state logic: trigger arbitration, ack handshake, timeout abort.
  always_comb begin
    state_d    = state_q;
    lba_d      = lba_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    loading_d  = loading_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    tmo_d      = tmo_q;
    start      = 1'b0;
    is_load    = 1'b0;
    save_start = 1'b0;
    load_done  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bk_ena) begin
          if (autoload_trig) begin
            start   = 1'b1;
            is_load = 1'b1;
          end else if (load_rise) begin
            start   = 1'b1;
            is_load = 1'b1;
          end else if (save_rise | auto_rise) begin
            start   = 1'b1;
            is_load = 1'b0;
          end
        end
        if (start) begin
          lba_d      = '0;
          loading_d  = is_load;
          rd_d       = is_load;
          wr_d       = ~is_load;
          busy_d     = 1'b1;
          err_d      = 1'b0;
          tmo_d      = '0;
          save_start = ~is_load;
          state_d    = REQ;
        end
      end

      REQ: begin
        if (ack_rise) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = XFER;
        end else if (tmo_q == TIMEOUT - 24'd1) begin
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          loading_d = 1'b0;
          busy_d    = 1'b0;
          err_d     = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
      end

      XFER: begin
        // No timeout here: an acknowledged sector always completes.
        if (ack_fall) begin
          if (last_sector) begin
            loading_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            load_done = loading_q;
            state_d   = IDLE;
          end else begin
            lba_d   = lba_q + LBA_W'(1);
            rd_d    = loading_q;
            wr_d    = ~loading_q;
            tmo_d   = '0;
            state_d = REQ;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign sd.sd_lba  = 32'(lba_q);
  assign sd.sd_rd   = rd_q;
  assign sd.sd_wr   = wr_q;
  assign bram_a     = {lba_q, sd.sd_buff_addr};
  assign bram_we    = sd.sd_buff_wr & sd.sd_ack & loading_q;
  assign bk_loading = loading_q;
  assign bk_busy    = busy_q;
  assign xfer_done  = done_q;
  assign xfer_err   = err_q;

endmodule

// File: tb/tb_bram_sync_ctrl.sv
// Bench for bram_sync_ctrl: acts as hps_io (random ack delays, 256-word
// sector bursts) and keeps its own picture of the dirty flag and of the
// sector sequence each transfer should produce.
module tb_bram_sync_ctrl;
  localparam int SECTORS = 4;
  localparam int LBA_W   = 2;
  localparam int TMO     = 100;

  logic             clk_sys = 1'b0;
  logic             reset;
  logic             downloading, img_mounted, img_readonly;
  logic [63:0]      img_size;
  logic             osd_status, autosave, load_req, save_req, bram_change;
  logic [LBA_W+7:0] bram_a;
  logic             bram_we, bk_ena, bk_loading, bk_busy, sav_pending, xfer_done, xfer_err;

  int vectors    = 0;
  int miscompares = 0;
  bit model_pend = 1'b0;

  bram_sync_ctrl_if sd_if ();

  bram_sync_ctrl #(
    .SECTORS (SECTORS),
    .LBA_W   (LBA_W),
    .TIMEOUT (24'(TMO))
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .downloading  (downloading),
    .img_mounted  (img_mounted),
    .img_readonly (img_readonly),
    .img_size     (img_size),
    .osd_status   (osd_status),
    .autosave     (autosave),
    .load_req     (load_req),
    .save_req     (save_req),
    .bram_change  (bram_change),
    .sd           (sd_if.master),
    .bram_a       (bram_a),
    .bram_we      (bram_we),
    .bk_ena       (bk_ena),
    .bk_loading   (bk_loading),
    .bk_busy      (bk_busy),
    .sav_pending  (sav_pending),
    .xfer_done    (xfer_done),
    .xfer_err     (xfer_err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // hps_io side of one sector: wait for request, ack after a random delay,
  // stream 256 words, drop ack, then check the follow-up.
  task automatic serve_sector(input bit is_load, input int idx, input bit rearm);
    int n, dly, we_cnt, addr_bad, hold_bad;
    logic [LBA_W+7:0] exp_a;
    n = 0;
    while (!(sd_if.sd_rd === 1'b1 || sd_if.sd_wr === 1'b1) && n < 50) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= 50) begin
      miscompares++;
      $display("FAIL req_wait: got no request after %0d cycles, expected one for lba %0d", n, idx);
    end
    vectors++;
    if ({sd_if.sd_rd, sd_if.sd_wr} !== {is_load, ~is_load}) begin
      miscompares++;
      $display("FAIL req_dir: got rd/wr %b%b, expected %b%b", sd_if.sd_rd, sd_if.sd_wr, is_load, ~is_load);
    end
    vectors++;
    if (sd_if.sd_lba !== 32'(idx)) begin
      miscompares++;
      $display("FAIL req_lba: got %0d, expected %0d", sd_if.sd_lba, idx);
    end
    vectors++;
    if (bk_loading !== is_load || bk_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL req_flags: got loading/busy %b%b, expected %b1", bk_loading, bk_busy, is_load);
    end
    dly = $urandom_range(1, 8);
    sd_if.sd_buff_wr   = 1'b1;
    sd_if.sd_buff_addr = 8'($urandom);
    repeat (dly) tick();
    vectors++;
    if (bram_we !== 1'b0) begin
      miscompares++;
      $display("FAIL we_no_ack: got %b, expected 0", bram_we);
    end
    sd_if.sd_buff_wr = 1'b0;
    sd_if.sd_ack     = 1'b1;
    tick();
    vectors++;
    if (sd_if.sd_rd !== 1'b0 || sd_if.sd_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL req_drop: got rd/wr %b%b, expected 00", sd_if.sd_rd, sd_if.sd_wr);
    end
    we_cnt = 0; addr_bad = 0; hold_bad = 0;
    for (int w = 0; w < 256; w++) begin
      sd_if.sd_buff_addr = w[7:0];
      sd_if.sd_buff_wr   = 1'b1;
      if (rearm && w == 100) begin
        bram_change = 1'b1;
        model_pend  = 1'b1;
      end
      #1;
      if (bram_we === 1'b1) we_cnt++;
      exp_a = (LBA_W+8)'((idx << 8) + w);
      if (bram_a !== exp_a) addr_bad++;
      if (bk_loading !== is_load || bk_busy !== 1'b1) hold_bad++;
      tick();
      bram_change = 1'b0;
    end
    vectors++;
    if (we_cnt != (is_load ? 256 : 0)) begin
      miscompares++;
      $display("FAIL we_count: got %0d, expected %0d (lba %0d)", we_cnt, is_load ? 256 : 0, idx);
    end
    vectors++;
    if (addr_bad != 0) begin
      miscompares++;
      $display("FAIL bram_a: got %0d wrong addresses, expected 0 (lba %0d)", addr_bad, idx);
    end
    vectors++;
    if (hold_bad != 0) begin
      miscompares++;
      $display("FAIL flags_hold: got %0d bad cycles, expected 0 (lba %0d)", hold_bad, idx);
    end
    sd_if.sd_buff_wr = 1'b0;
    sd_if.sd_ack     = 1'b0;
    tick();
    if (idx == SECTORS - 1) begin
      vectors++;
      if (xfer_done !== 1'b1 || bk_busy !== 1'b0 || bk_loading !== 1'b0 ||
          sd_if.sd_rd !== 1'b0 || sd_if.sd_wr !== 1'b0) begin
        miscompares++;
        $display("FAIL done: got done/busy/loading/rd/wr %b%b%b%b%b, expected 10000",
                 xfer_done, bk_busy, bk_loading, sd_if.sd_rd, sd_if.sd_wr);
      end
      tick();
      vectors++;
      if (xfer_done !== 1'b0) begin
        miscompares++;
        $display("FAIL done_pulse: got %b one cycle later, expected 0", xfer_done);
      end
    end else begin
      vectors++;
      if ({sd_if.sd_rd, sd_if.sd_wr} !== {is_load, ~is_load} || sd_if.sd_lba !== 32'(idx + 1)) begin
        miscompares++;
        $display("FAIL rerequest: got rd/wr %b%b lba %0d, expected %b%b lba %0d",
                 sd_if.sd_rd, sd_if.sd_wr, sd_if.sd_lba, is_load, ~is_load, idx + 1);
      end
    end
  endtask

  task automatic run_xfer(input bit is_load, input int rearm_at);
    for (int s = 0; s < SECTORS; s++) serve_sector(is_load, s, s == rearm_at);
    if (is_load) model_pend = 1'b0;
  endtask

  task automatic check_pending(input string tag);
    vectors++;
    if (sav_pending !== model_pend) begin
      miscompares++;
      $display("FAIL pending_%s: got %b, expected %b", tag, sav_pending, model_pend);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    downloading = 0; img_mounted = 0; img_readonly = 0; img_size = '0;
    osd_status = 0; autosave = 0; load_req = 0; save_req = 0; bram_change = 0;
    sd_if.sd_ack = 0; sd_if.sd_buff_addr = '0; sd_if.sd_buff_wr = 0;
    tick(); tick();
    reset = 1'b0;
    tick();
    vectors++;
    if (sd_if.sd_lba !== 32'd0 || sd_if.sd_rd !== 1'b0 || sd_if.sd_wr !== 1'b0 ||
        bk_ena !== 1'b0 || bk_loading !== 1'b0 || bk_busy !== 1'b0 || sav_pending !== 1'b0 ||
        xfer_done !== 1'b0 || xfer_err !== 1'b0 || bram_we !== 1'b0 || bram_a !== '0) begin
      miscompares++;
      $display("FAIL reset: got lba %0h rd %b wr %b ena %b ld %b busy %b pend %b done %b err %b we %b a %0h, expected all 0",
               sd_if.sd_lba, sd_if.sd_rd, sd_if.sd_wr, bk_ena, bk_loading, bk_busy,
               sav_pending, xfer_done, xfer_err, bram_we, bram_a);
    end
  endtask

  task automatic test_gating();
    save_req = 1'b1;
    repeat (3) tick();
    vectors++;
    if (sd_if.sd_wr !== 1'b0 || bk_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL gating: got wr/busy %b%b with bk_ena=0, expected 00", sd_if.sd_wr, bk_busy);
    end
    save_req = 1'b0;
    tick();
  endtask

  task automatic test_autoload();
    downloading = 1'b1;
    tick();
    img_mounted = 1'b1;
    img_size    = 64'd8192;
    tick();
    img_mounted = 1'b0;
    vectors++;
    if (bk_ena !== 1'b1) begin
      miscompares++;
      $display("FAIL mount: got bk_ena %b, expected 1", bk_ena);
    end
    tick();
    downloading = 1'b0;
    tick();
    run_xfer(1'b1, -1);
    check_pending("autoload");
  endtask

  task automatic test_autosave();
    bram_change = 1'b1;
    tick();
    bram_change = 1'b0;
    model_pend  = 1'b1;
    check_pending("set");
    autosave   = 1'b1;
    osd_status = 1'b1;
    tick();
    model_pend = 1'b0;
    check_pending("save_start");
    run_xfer(1'b0, -1);
    osd_status = 1'b0;
    autosave   = 1'b0;
    tick();
    check_pending("autosave_end");
  endtask

  task automatic test_rearm();
    save_req = 1'b1;
    tick();
    model_pend = 1'b0;
    run_xfer(1'b0, 2);
    save_req = 1'b0;
    tick();
    check_pending("rearm");
  endtask

  task automatic test_timeout();
    int cnt;
    save_req = 1'b1;
    tick();
    model_pend = 1'b0;
    cnt = 0;
    while (sd_if.sd_wr === 1'b1 && cnt < 300) begin
      cnt++;
      tick();
    end
    vectors++;
    if (cnt != TMO) begin
      miscompares++;
      $display("FAIL timeout_len: got %0d cycles of sd_wr, expected %0d", cnt, TMO);
    end
    vectors++;
    if (xfer_err !== 1'b1 || bk_busy !== 1'b0 || bk_loading !== 1'b0 || xfer_done !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_flags: got err/busy/ld/done %b%b%b%b, expected 1000",
               xfer_err, bk_busy, bk_loading, xfer_done);
    end
    check_pending("timeout");
    save_req = 1'b0;
    tick();
    save_req = 1'b1;
    tick();
    vectors++;
    if (xfer_err !== 1'b0 || sd_if.sd_wr !== 1'b1) begin
      miscompares++;
      $display("FAIL err_clear: got err/wr %b%b, expected 01", xfer_err, sd_if.sd_wr);
    end
    run_xfer(1'b0, -1);
    save_req = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    downloading = 1'b1;
    img_mounted = 1'b1;
    tick();
    img_mounted = 1'b0;
    vectors++;
    if (bk_ena !== 1'b1) begin
      miscompares++;
      $display("FAIL set_wins: got bk_ena %b, expected 1", bk_ena);
    end
    tick();
    downloading = 1'b0;
    save_req    = 1'b1;
    tick();
    vectors++;
    if (sd_if.sd_rd !== 1'b1 || sd_if.sd_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL priority: got rd/wr %b%b, expected 10", sd_if.sd_rd, sd_if.sd_wr);
    end
    load_req = 1'b1;
    run_xfer(1'b1, -1);
    repeat (5) tick();
    vectors++;
    if (sd_if.sd_rd !== 1'b0 || sd_if.sd_wr !== 1'b0 || bk_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_ignore: got rd/wr/busy %b%b%b, expected 000", sd_if.sd_rd, sd_if.sd_wr, bk_busy);
    end
    load_req = 1'b0;
    save_req = 1'b0;
    tick();
    check_pending("priority");
  endtask

  task automatic test_random();
    bit is_load;
    int r, rearm_at;
    img_size = '0;
    for (int it = 0; it < 6; it++) begin
      is_load = 1'($urandom);
      r = $urandom_range(0, 2);
      if (r == 1) begin
        bram_change = 1'b1;
        model_pend  = 1'b1;
      end else if (r == 2) begin
        bram_change = 1'b1;
        osd_status  = 1'b1;
      end
      tick();
      bram_change = 1'b0;
      osd_status  = 1'b0;
      tick();
      check_pending("rand_pre");
      rearm_at = -1;
      if (is_load) begin
        load_req = 1'b1;
      end else begin
        save_req   = 1'b1;
        model_pend = 1'b0;
        if ($urandom_range(0, 1) == 1) rearm_at = $urandom_range(0, SECTORS - 1);
      end
      tick();
      run_xfer(is_load, rearm_at);
      load_req = 1'b0;
      save_req = 1'b0;
      tick();
      check_pending("rand_post");
    end
  endtask

  task automatic test_reset_mid();
    load_req = 1'b1;
    tick();
    serve_sector(1'b1, 0, 1'b0);
    sd_if.sd_ack = 1'b1;
    tick();
    sd_if.sd_buff_wr = 1'b1;
    reset = 1'b1;
    tick();
    vectors++;
    if (sd_if.sd_rd !== 1'b0 || sd_if.sd_wr !== 1'b0 || bk_loading !== 1'b0 ||
        bk_ena !== 1'b0 || bk_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got rd/wr/ld/ena/busy %b%b%b%b%b, expected 00000",
               sd_if.sd_rd, sd_if.sd_wr, bk_loading, bk_ena, bk_busy);
    end
    reset = 1'b0;
    model_pend = 1'b0;
    sd_if.sd_buff_wr = 1'b0;
    tick();
    sd_if.sd_ack = 1'b0;
    load_req = 1'b0;
    tick(); tick();
    load_req = 1'b1;
    tick(); tick();
    vectors++;
    if (sd_if.sd_rd !== 1'b0 || sd_if.sd_wr !== 1'b0 || bk_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got rd/wr/busy %b%b%b, expected 000", sd_if.sd_rd, sd_if.sd_wr, bk_busy);
    end
    check_pending("reset_mid");
    load_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_gating();
    test_autoload();
    test_autosave();
    test_rearm();
    test_timeout();
    test_priority();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
